led_period_meter: RTL and testbench

//  Receive side of the LED blink path: samples a toggling 1-bit signal (e.g. the

---
 rtl/led_period_meter.sv | 102 ++++++++++
 tb/tb_led_period_meter.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/led_period_meter.sv
// led_period_meter: measures high/low durations of an asynchronous 1-bit signal in sys_clk cycles,
// reporting one pair per complete period with a strobe, plus a sticky stuck-signal timeout.
module led_period_meter #(
    parameter int          CNT_W       = 26,
    parameter int unsigned TIMEOUT     = 50_000_000,
    parameter int          SYNC_STAGES = 2
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             sig_in,
    input  logic             meas_en,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] low_cnt,
    output logic             meas_valid,
    output logic             timeout
);
    typedef enum logic [2:0] {IDLE, WAIT_EDGE, MEAS_LOW_PRE, MEAS_HIGH, MEAS_LOW} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   sig_d_q, sig_d_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       hi_tmp_q, hi_tmp_d;
    logic [CNT_W-1:0]       high_cnt_q, high_cnt_d;
    logic [CNT_W-1:0]       low_cnt_q, low_cnt_d;
    logic                   meas_valid_q, meas_valid_d;
    logic                   timeout_q, timeout_d;
    logic                   sig_s, rise, fall, tmo;

    assign sig_s = sync_q[SYNC_STAGES-1];
    assign rise  = sig_s & ~sig_d_q;
    assign fall  = ~sig_s & sig_d_q;
    // An edge in the same cycle as the limit is still a valid edge, not a timeout.
    assign tmo   = (64'(cnt_q) == 64'(TIMEOUT)) & ~(rise | fall);

    assign high_cnt   = high_cnt_q;
    assign low_cnt    = low_cnt_q;
    assign meas_valid = meas_valid_q;
    assign timeout    = timeout_q;

    always_comb begin
        sync_d       = {sync_q[SYNC_STAGES-2:0], sig_in};
        sig_d_d      = sig_s;
        state_d      = state_q;
        cnt_d        = (rise | fall) ? CNT_W'(1) : (&cnt_q ? cnt_q : cnt_q + CNT_W'(1));
        hi_tmp_d     = hi_tmp_q;
        high_cnt_d   = high_cnt_q;
        low_cnt_d    = low_cnt_q;
        meas_valid_d = 1'b0;
        timeout_d    = timeout_q;
        if (state_q == IDLE || !meas_en) begin
            cnt_d     = '0;
            timeout_d = 1'b0;
            state_d   = (state_q == IDLE && meas_en) ? WAIT_EDGE : IDLE;
        end else if (tmo) begin
            cnt_d     = '0;
            timeout_d = 1'b1;
            state_d   = WAIT_EDGE;
        end else begin
            case (state_q)
                WAIT_EDGE:    state_d = rise ? MEAS_HIGH : (fall ? MEAS_LOW_PRE : WAIT_EDGE);
                MEAS_LOW_PRE: state_d = rise ? MEAS_HIGH : MEAS_LOW_PRE;
                MEAS_HIGH: if (fall) begin
                    hi_tmp_d = cnt_q;
                    state_d  = MEAS_LOW;
                end
                MEAS_LOW: if (rise) begin
                    high_cnt_d   = hi_tmp_q;
                    low_cnt_d    = cnt_q;
                    meas_valid_d = 1'b1;
                    timeout_d    = 1'b0;
                    state_d      = MEAS_HIGH;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q      <= IDLE;
            sync_q       <= '0;
            sig_d_q      <= 1'b0;
            cnt_q        <= '0;
            hi_tmp_q     <= '0;
            high_cnt_q   <= '0;
            low_cnt_q    <= '0;
            meas_valid_q <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync_q       <= sync_d;
            sig_d_q      <= sig_d_d;
            cnt_q        <= cnt_d;
            hi_tmp_q     <= hi_tmp_d;
            high_cnt_q   <= high_cnt_d;
            low_cnt_q    <= low_cnt_d;
            meas_valid_q <= meas_valid_d;
            timeout_q    <= timeout_d;
        end
    end
endmodule

// File: tb/tb_led_period_meter.sv
// tb_led_period_meter: directed checks of led_period_meter with a short TIMEOUT of 100 cycles.
module tb_led_period_meter;
    localparam int CNT_W = 26;

    logic             sys_clk = 1'b0;
    logic             sys_rst = 1'b1;
    logic             sig_in = 1'b0;
    logic             meas_en = 1'b0;
    logic [CNT_W-1:0] high_cnt, low_cnt;
    logic             meas_valid, timeout;

    int checks = 0;
    int errors = 0;
    int n_valid = 0;
    int cyc_n = 0;
    int last_cyc = 0;
    int gap = 0;
    int n0;

    led_period_meter #(.CNT_W(CNT_W), .TIMEOUT(100), .SYNC_STAGES(2)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .sig_in(sig_in), .meas_en(meas_en),
        .high_cnt(high_cnt), .low_cnt(low_cnt), .meas_valid(meas_valid), .timeout(timeout)
    );

    always #5 sys_clk = ~sys_clk;

    // Strobe monitor: counts strobes and records the spacing of the last two.
    always @(negedge sys_clk) begin
        cyc_n <= cyc_n + 1;
        if (!sys_rst && meas_valid) begin
            n_valid  <= n_valid + 1;
            gap      <= cyc_n - last_cyc;
            last_cyc <= cyc_n;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic seg(input logic lvl, input int n);
        sig_in = lvl;
        cyc(n);
    endtask

    task automatic periods(input int hi, input int lo, input int k);
        repeat (k) begin
            seg(1'b1, hi);
            seg(1'b0, lo);
        end
    endtask

    initial begin
        #12;
        chk("rst_high", 32'(high_cnt), 0);
        chk("rst_low", 32'(low_cnt), 0);
        chk("rst_valid", 32'(meas_valid), 0);
        chk("rst_timeout", 32'(timeout), 0);
        @(posedge sys_clk); #1;
        sys_rst = 1'b0;
        meas_en = 1'b1;
        cyc(3);

        n0 = n_valid;
        periods(25, 25, 4);
        cyc(1);
        chk("t1_count", 32'(n_valid - n0), 3);
        chk("t1_high", 32'(high_cnt), 25);
        chk("t1_low", 32'(low_cnt), 25);
        chk("t1_gap", 32'(gap), 50);

        n0 = n_valid;
        periods(3, 7, 5);
        chk("t2_count", 32'(n_valid - n0), 5);
        chk("t2_high", 32'(high_cnt), 3);
        chk("t2_low", 32'(low_cnt), 7);
        chk("t2_gap", 32'(gap), 10);
        sig_in = 1'b1;
        cyc(2);
        chk("t2_lat_early", 32'(meas_valid), 0);
        cyc(1);
        chk("t2_lat_on", 32'(meas_valid), 1);
        chk("t2_lat_high", 32'(high_cnt), 3);
        cyc(1);
        chk("t2_lat_off", 32'(meas_valid), 0);

        seg(1'b0, 1);
        n0 = n_valid;
        periods(1, 1, 6);
        cyc(2);
        chk("t6_count", 32'(n_valid - n0), 6);
        chk("t6_high", 32'(high_cnt), 1);
        chk("t6_low", 32'(low_cnt), 1);
        chk("t6_gap", 32'(gap), 2);

        meas_en = 1'b0;
        seg(1'b1, 5);
        n0 = n_valid;
        meas_en = 1'b1;
        cyc(101);
        chk("t3_before", 32'(timeout), 0);
        cyc(1);
        chk("t3_timeout", 32'(timeout), 1);
        seg(1'b1, 50);
        chk("t3_no_strobe", 32'(n_valid - n0), 0);
        chk("t3_sticky", 32'(timeout), 1);
        seg(1'b0, 5); seg(1'b1, 5); seg(1'b0, 5); seg(1'b1, 5);
        chk("t3_count", 32'(n_valid - n0), 1);
        chk("t3_high", 32'(high_cnt), 5);
        chk("t3_low", 32'(low_cnt), 5);
        chk("t3_cleared", 32'(timeout), 0);

        periods(4, 6, 3);
        chk("t4_high_pre", 32'(high_cnt), 4);
        chk("t4_low_pre", 32'(low_cnt), 6);
        seg(1'b1, 120);
        chk("t4_timeout_set", 32'(timeout), 1);
        meas_en = 1'b0;
        cyc(1);
        chk("t4_timeout_clr", 32'(timeout), 0);
        n0 = n_valid;
        seg(1'b1, 3); seg(1'b0, 4); seg(1'b1, 3); seg(1'b0, 4);
        chk("t4_idle_count", 32'(n_valid - n0), 0);
        chk("t4_hold_high", 32'(high_cnt), 4);
        chk("t4_hold_low", 32'(low_cnt), 6);
        meas_en = 1'b1;
        seg(1'b0, 3); seg(1'b1, 2); seg(1'b0, 8); seg(1'b1, 4); seg(1'b0, 2);
        chk("t4_count", 32'(n_valid - n0), 1);
        chk("t4_high", 32'(high_cnt), 2);
        chk("t4_low", 32'(low_cnt), 8);

        periods(7, 3, 2);
        chk("t5_high_pre", 32'(high_cnt), 7);
        sig_in = 1'b1;
        cyc(2);
        #3;
        sys_rst = 1'b1;
        #1;
        chk("t5_rst_high", 32'(high_cnt), 0);
        chk("t5_rst_low", 32'(low_cnt), 0);
        chk("t5_rst_valid", 32'(meas_valid), 0);
        chk("t5_rst_timeout", 32'(timeout), 0);
        sig_in = 1'b0;
        cyc(2);
        sys_rst = 1'b0;
        n0 = n_valid;
        seg(1'b0, 5); seg(1'b1, 6); seg(1'b0, 9); seg(1'b1, 4); seg(1'b0, 2);
        chk("t5_count", 32'(n_valid - n0), 1);
        chk("t5_high", 32'(high_cnt), 6);
        chk("t5_low", 32'(low_cnt), 9);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
